ps2_key_scheduler: RTL and testbench

PS2_KEY_SCHEDULER -- requirements
Module: ps2_key_scheduler

---
 rtl/ps2_key_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_key_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_scheduler.sv
// PS/2 scancode decoder and event scheduler.
// Received bytes are decoded into key events. The decoder strips the E0 and
// F0 prefixes and records them as the ext and brk flags of each event.
// Events are held in a small circular FIFO until the consumer acknowledges them.
module ps2_key_scheduler #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  input  logic       ev_ack,
  input  logic       ovf_clr,
  output logic       overflow,
  output logic       seq_err
);

  localparam int            AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic [15:0]   to_cnt_r;
  logic          run_r;
  logic          byte_s;
  logic          push_s;
  logic          push_ext_s;
  logic          push_brk_s;
  logic          err_s;

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [9:0]    mem_r [FIFO_DEPTH];
  logic [9:0]    head_s;
  logic          pop_s;
  logic          full_s;
  logic          wr_en_s;
  logic          drop_s;

  // A byte only counts once the block has seen one clock edge out of reset.
  assign byte_s = rx_ready & run_r;

  // Decode the received byte against the current prefix state. The timeout applies only when no byte arrives.
  always_comb begin
    state_nx_s = state_r;
    push_s     = 1'b0;
    push_ext_s = 1'b0;
    push_brk_s = 1'b0;
    err_s      = 1'b0;
    if (byte_s) begin
      if ((rx_data == 8'h00) || (rx_data == 8'hFF)) begin
        state_nx_s = IDLE;
        err_s      = 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            case (rx_data)
              8'hE0:   state_nx_s = GOT_E0;
              8'hF0:   state_nx_s = GOT_F0;
              default: push_s     = 1'b1;
            endcase
          end
          GOT_E0: begin
            case (rx_data)
              8'hF0:   state_nx_s = GOT_E0F0;
              8'hE0:   state_nx_s = GOT_E0;
              default: begin
                push_s     = 1'b1;
                push_ext_s = 1'b1;
                state_nx_s = IDLE;
              end
            endcase
          end
          GOT_F0: begin
            case (rx_data)
              8'hF0:   state_nx_s = GOT_F0;
              8'hE0: begin
                state_nx_s = GOT_E0;
                err_s      = 1'b1;
              end
              default: begin
                push_s     = 1'b1;
                push_brk_s = 1'b1;
                state_nx_s = IDLE;
              end
            endcase
          end
          GOT_E0F0: begin
            case (rx_data)
              8'hE0, 8'hF0: begin
                state_nx_s = IDLE;
                err_s      = 1'b1;
              end
              default: begin
                push_s     = 1'b1;
                push_ext_s = 1'b1;
                push_brk_s = 1'b1;
                state_nx_s = IDLE;
              end
            endcase
          end
          default: state_nx_s = IDLE;
        endcase
      end
    end else if ((state_r != IDLE) && (to_cnt_r == (TIMEOUT - 16'd1))) begin
      state_nx_s = IDLE;
      err_s      = 1'b1;
    end else begin
      state_nx_s = state_r;
    end
  end

  // Mark the first edge after reset release so the byte arriving on that edge is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // Decoder state, inter-byte timeout counter and registered error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      to_cnt_r <= 16'd0;
      seq_err  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      seq_err <= err_s;
      if (rx_ready || (state_r == IDLE)) begin
        to_cnt_r <= 16'd0;
      end else begin
        to_cnt_r <= to_cnt_r + 16'd1;
      end
    end
  end

  // A push into a full FIFO succeeds only when a pop frees a slot on the same edge.
  assign full_s  = (count_r == FULL_CNT);
  assign pop_s   = ev_valid & ev_ack;
  assign wr_en_s = push_s & (~full_s | pop_s);
  assign drop_s  = push_s & full_s & ~pop_s;

  // Event storage, circular pointers and occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 10'd0;
      end
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= {push_ext_s, push_brk_s, rx_data};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow flag. A new drop takes priority over a clear on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop_s) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end else begin
      overflow <= overflow;
    end
  end

  // The head entry is shown directly from storage and is masked to zero when the FIFO is empty.
  assign head_s   = mem_r[rd_ptr_r];
  assign ev_valid = (count_r != {(AW+1){1'b0}});
  assign ev_code  = ev_valid ? head_s[7:0] : 8'h00;
  assign ev_ext   = ev_valid & head_s[9];
  assign ev_break = ev_valid & head_s[8];

endmodule

// File: tb/tb_ps2_key_scheduler.sv
// Testbench for ps2_key_scheduler.
// A reference model of the prefix rules, the timeout and the FIFO runs in step
// with the clock and pushes the expected events into a scoreboard queue. A
// separate monitor compares the scoreboard against each event the DUT presents.
module tb_ps2_key_scheduler;

  localparam int          DEPTH = 4;
  localparam logic [15:0] TO    = 16'd8;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       ev_ack   = 1'b0;
  logic       ovf_clr  = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       overflow;
  logic       seq_err;

  ps2_key_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext),
    .ev_break (ev_break),
    .ev_ack   (ev_ack),
    .ovf_clr  (ovf_clr),
    .overflow (overflow),
    .seq_err  (seq_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  int  checks = 0;
  int  errors = 0;
  ev_t mq[$];
  ev_t sb[$];
  bit  m_ext   = 1'b0;
  bit  m_brk   = 1'b0;
  int  gap     = 0;
  bit  exp_se  = 1'b0;
  bit  exp_ovf = 1'b0;
  bit  ign     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one clock edge with the given inputs.
  task automatic model_edge(input bit rr, input logic [7:0] rd, input bit ack, input bit clr);
    bit  rr_eff = rr;
    bit  se     = 1'b0;
    bit  push   = 1'b0;
    bit  full;
    bit  pop;
    bit  oset   = 1'b0;
    ev_t e;
    if (ign) begin
      ign    = 1'b0;
      rr_eff = 1'b0;
    end
    if (rr_eff) begin
      gap = 0;
      if (rd == 8'h00 || rd == 8'hFF) begin
        se = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
      end else if (rd == 8'hE0) begin
        if (m_brk) begin
          se = 1'b1;
          m_ext = !m_ext;
          m_brk = 1'b0;
        end else begin
          m_ext = 1'b1;
        end
      end else if (rd == 8'hF0) begin
        if (m_ext && m_brk) begin
          se = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
        end else begin
          m_brk = 1'b1;
        end
      end else begin
        push = 1'b1;
        e = '{code: rd, ext: m_ext, brk: m_brk};
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end else begin
      gap++;
      if ((m_ext || m_brk) && gap == int'(TO)) begin
        se = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
      end
    end
    full = (mq.size() == DEPTH);
    pop  = ack && (mq.size() != 0);
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (full && !pop) begin
        oset = 1'b1;
      end else begin
        mq.push_back(e);
        sb.push_back(e);
      end
    end
    if (oset) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    exp_se = se;
  endtask

  // One clock cycle: drive, check at the falling edge, then advance the model.
  task automatic cycle(input bit rr, input logic [7:0] rd, input bit ack, input bit clr);
    rx_ready = rr; rx_data = rd; ev_ack = ack; ovf_clr = clr;
    @(negedge clk);
    chk("ev_valid", ev_valid, mq.size() != 0);
    chk("seq_err", seq_err, exp_se);
    chk("overflow", overflow, exp_ovf);
    @(posedge clk);
    model_edge(rr, rd, ack, clr);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit ack);
    cycle(1'b1, b, ack, 1'b0);
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, ack, 1'b0);
  endtask

  task automatic do_reset(input int cyc);
    rx_ready = 1'b0; ev_ack = 1'b0; ovf_clr = 1'b0;
    reset = 1'b0;
    #1;
    mq.delete(); sb.delete();
    m_ext = 1'b0; m_brk = 1'b0; gap = 0; exp_se = 1'b0; exp_ovf = 1'b0;
    chk("rst_ev_valid", ev_valid, 1'b0);
    chk("rst_ev_code", ev_code, 8'h00);
    chk("rst_ev_ext", ev_ext, 1'b0);
    chk("rst_ev_break", ev_break, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_seq_err", seq_err, 1'b0);
    repeat (cyc) @(posedge clk);
    #1;
    reset = 1'b1;
    ign   = 1'b1;
  endtask

  // Monitor: compare every event the DUT hands over against the scoreboard.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset && ev_valid && ev_ack) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event actual=%0h/%0b/%0b required=none", ev_code, ev_ext, ev_break);
        end else begin
          e = sb.pop_front();
          chk("ev_code", ev_code, e.code);
          chk("ev_ext", ev_ext, e.ext);
          chk("ev_break", ev_break, e.brk);
        end
      end
    end
  end

  initial begin
    int r;
    logic [7:0] b;
    bit ack;
    do_reset(2);
    // Basic make/break/extended sequences with the consumer always ready.
    send(8'h1C, 1'b1);
    send(8'hE0, 1'b1); send(8'h75, 1'b1);
    send(8'hF0, 1'b1); send(8'h1C, 1'b1);
    send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h75, 1'b1);
    idle(3, 1'b1);
    // Fill the FIFO, overflow on the fifth event, then clear the flag.
    for (int i = 0; i < 5; i++) send(8'h15 + 8'(i), 1'b0);
    idle(2, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2, 1'b0);
    // Push and pop together while full.
    send(8'h1A, 1'b1);
    idle(2, 1'b0);
    idle(6, 1'b1);
    // Timeout after a lone F0 prefix.
    send(8'hF0, 1'b1);
    idle(8, 1'b1);
    send(8'h1C, 1'b1);
    idle(3, 1'b1);
    // Malformed sequence, recovery, and a keyboard error byte.
    send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'hE0, 1'b1);
    send(8'h2B, 1'b1);
    send(8'hFF, 1'b1);
    idle(3, 1'b1);
    // Reset with a partial prefix and queued events. The byte in the release cycle is ignored.
    send(8'h2A, 1'b0); send(8'h2B, 1'b0); send(8'hF0, 1'b0);
    do_reset(2);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    send(8'h1C, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);
    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) b = 8'h00;
      else if (r < 8) b = 8'hFF;
      else if (r < 28) b = 8'hE0;
      else if (r < 45) b = 8'hF0;
      else b = 8'($urandom_range(0, 255));
      ack = (n % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle(1'b1, b, ack, $urandom_range(0, 15) == 0);
      for (int g = $urandom_range(0, 11); g > 0; g--) begin
        ack = (n % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        cycle(1'b0, 8'h00, ack, $urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 149) == 0) begin
        do_reset($urandom_range(1, 3));
        cycle($urandom_range(0, 1) == 1, 8'h1C, 1'b0, 1'b0);
      end
    end
    idle(DEPTH + 4, 1'b1);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
